// File: rtl/rng_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rng_pkg
// Purpose  : Shared types and constants for the range sampler and any other
//            consumer of the upstream PRNG.
// Revision : 1.0  initial release
// ============================================================================
package rng_pkg;

  localparam int RNG_W           = 10;
  localparam int MAX_TRIES_LIMIT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/range_mask.sv
`default_nettype none
// ============================================================================
// Module   : range_mask
// Purpose  : Smallest all-ones mask (2^k-1) covering Limit-1; zero when
//            Limit <= 1. Purely combinational, shared by range consumers.
// Revision : 1.0  initial release
// ============================================================================
module range_mask
  import rng_pkg::*;
(
  input  logic [RNG_W-1:0] Limit,
  output logic [RNG_W-1:0] Mask
);

  logic [RNG_W-1:0] w_lm1;
  logic [RNG_W-1:0] w_fill;

  // Smear the highest set bit of Limit-1 into every lower bit position
  always_comb begin
    w_lm1  = (Limit > RNG_W'(1)) ? (Limit - RNG_W'(1)) : '0;
    w_fill = w_lm1;
    for (int s = 1; s < RNG_W; s = s * 2) begin
      w_fill = w_fill | (w_fill >> s);
    end
    Mask = w_fill;
  end

endmodule
`default_nettype wire

// File: rtl/rng_range_sampler.sv
`default_nettype none
// ============================================================================
// Module   : rng_range_sampler
// Purpose  : Draws a value in [0, Limit-1] from a free-running PRNG by masked
//            rejection sampling, with a bounded number of tries and a single
//            subtraction fallback so latency never exceeds MAX_TRIES cycles.
// Revision : 1.0  initial release
// ============================================================================
module rng_range_sampler
  import rng_pkg::*;
#(
  parameter int MAX_TRIES = 8
)(
  input  logic             Clk,
  input  logic             Reset,
  input  logic [RNG_W-1:0] Rand,
  input  logic             Req,
  input  logic [RNG_W-1:0] Limit,
  input  logic             Ack,
  output logic [RNG_W-1:0] Value,
  output logic             Valid,
  output logic             Busy,
  output logic [3:0]       Rejects
);

  // Index of the final try; on a reject here the fallback path is taken
  localparam logic [3:0] c_LAST_TRY = 4'(MAX_TRIES - 1);

  state_t           r_state,   w_state_n;
  logic [RNG_W-1:0] r_limit,   w_limit_n;
  logic [RNG_W-1:0] r_mask,    w_mask_n;
  logic [3:0]       r_tries,   w_tries_n;
  logic [RNG_W-1:0] r_value,   w_value_n;
  logic             r_valid,   w_valid_n;
  logic [3:0]       r_rejects, w_rejects_n;

  logic [RNG_W-1:0] w_mask;
  logic [RNG_W-1:0] w_m;
  logic             w_accept;
  logic [3:0]       w_rej_inc;

  // Mask for the live Limit input; captured only when a request is accepted
  range_mask u_range_mask (
    .Limit (Limit),
    .Mask  (w_mask)
  );

  // Candidate sample and accept test; Limit 0 has no legal range, so it
  // is forced to accept the masked value, which is 0 because its mask is 0
  always_comb begin
    w_m       = Rand & r_mask;
    w_accept  = (r_limit <= RNG_W'(1)) || (w_m < r_limit);
    // With MAX_TRIES=16 the reject count can reach 16; hold at 15 rather
    // than wrap back to 0 in the 4-bit output
    w_rej_inc = (r_rejects == 4'hF) ? r_rejects : (r_rejects + 4'd1);
  end

  // Next-state and next-datapath decode
  always_comb begin
    w_state_n   = r_state;
    w_limit_n   = r_limit;
    w_mask_n    = r_mask;
    w_tries_n   = r_tries;
    w_value_n   = r_value;
    w_valid_n   = r_valid;
    w_rejects_n = r_rejects;
    case (r_state)
      IDLE: begin
        if (Req) begin
          w_limit_n   = Limit;
          w_mask_n    = w_mask;
          w_tries_n   = '0;
          w_rejects_n = '0;
          w_state_n   = SAMPLE;
        end
      end
      SAMPLE: begin
        if (w_accept) begin
          w_value_n = w_m;
          w_valid_n = 1'b1;
          w_state_n = DONE;
        end else if (r_tries == c_LAST_TRY) begin
          // M <= 2*Limit-1 here, so M-Limit is in range and never wraps
          w_value_n   = w_m - r_limit;
          w_rejects_n = w_rej_inc;
          w_valid_n   = 1'b1;
          w_state_n   = DONE;
        end else begin
          w_tries_n   = r_tries + 4'd1;
          w_rejects_n = w_rej_inc;
        end
      end
      DONE: begin
        if (Ack) begin
          w_valid_n = 1'b0;
          w_state_n = IDLE;
        end
      end
      default: begin
        w_state_n = IDLE;
        w_valid_n = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_limit   <= '0;
      r_mask    <= '0;
      r_tries   <= '0;
      r_value   <= '0;
      r_valid   <= 1'b0;
      r_rejects <= '0;
    end else begin
      r_state   <= w_state_n;
      r_limit   <= w_limit_n;
      r_mask    <= w_mask_n;
      r_tries   <= w_tries_n;
      r_value   <= w_value_n;
      r_valid   <= w_valid_n;
      r_rejects <= w_rejects_n;
    end
  end

  assign Value   = r_value;
  assign Valid   = r_valid;
  assign Busy    = (r_state != IDLE);
  assign Rejects = r_rejects;

endmodule
`default_nettype wire

// File: tb/tb_rng_range_sampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_rng_range_sampler
// Purpose  : Self-checking bench for rng_range_sampler: directed vector table,
//            randomized transactions against a reference model, and
//            hand-written reset / handshake corner sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_rng_range_sampler;

  localparam int MT = 8;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [9:0] Rand;
  logic       Req;
  logic [9:0] Limit;
  logic       Ack;
  logic [9:0] Value;
  logic       Valid;
  logic       Busy;
  logic [3:0] Rejects;

  int n_vec  = 0;
  int n_fail = 0;
  int cur_r[MT];

  typedef struct {
    int limit;
    int r0, r1, r2, rest;
    int ev, er, elat;
  } vec_t;

  vec_t tbl[11];

  rng_range_sampler #(.MAX_TRIES(MT)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Rand    (Rand),
    .Req     (Req),
    .Limit   (Limit),
    .Ack     (Ack),
    .Value   (Value),
    .Valid   (Valid),
    .Busy    (Busy),
    .Rejects (Rejects)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: rejection sampling from the rules, one try per listed value
  task automatic model(input int lim, output int ev, output int er, output int elat);
    int mask;
    int m;
    mask = 0;
    if (lim > 1)
      while (mask < lim - 1) mask = mask * 2 + 1;
    ev = 0; er = 0; elat = MT;
    for (int i = 0; i < MT; i++) begin
      m = cur_r[i] & mask;
      if (lim <= 1 || m < lim) begin
        ev = m; elat = i + 1;
        break;
      end
      er++;
      if (i == MT - 1) ev = m - lim;
    end
  endtask

  // One full request/response: inputs change on falling edges, checks there too
  task automatic run_txn(input int lim, input int ev, input int er, input int elat,
                         input bit req_at_ack, input string tag);
    @(negedge Clk);
    Req = 1'b1; Limit = lim[9:0]; Ack = 1'b0;
    @(negedge Clk);
    check({tag, " busy_after_accept"}, Busy, 1);
    for (int i = 0; i < elat; i++) begin
      // Req, Ack and Limit wiggle freely while sampling: all must be ignored
      Req   = 1'($urandom_range(0, 1));
      Ack   = 1'($urandom_range(0, 1));
      Limit = 10'($urandom_range(0, 1023));
      Rand  = cur_r[i][9:0];
      @(negedge Clk);
      check({tag, " valid_timing"}, Valid, (i == elat - 1) ? 1 : 0);
    end
    Req = 1'b0; Ack = 1'b0;
    check({tag, " value"}, Value, ev);
    check({tag, " rejects"}, Rejects, er);
    check({tag, " busy_done"}, Busy, 1);
    repeat (2) begin
      Rand = 10'($urandom_range(0, 1023));
      @(negedge Clk);
      check({tag, " valid_hold"}, Valid, 1);
      check({tag, " value_hold"}, Value, ev);
    end
    Ack = 1'b1; Req = req_at_ack;
    @(negedge Clk);
    Ack = 1'b0; Req = 1'b0;
    check({tag, " valid_after_ack"}, Valid, 0);
    check({tag, " busy_after_ack"}, Busy, 0);
    check({tag, " value_after_ack"}, Value, ev);
    check({tag, " rejects_after_ack"}, Rejects, er);
    @(negedge Clk);
    check({tag, " stays_idle"}, Busy, 0);
  endtask

  initial begin
    int ev, er, elat, lim;

    tbl[0]  = '{6,    5,    5,    5,    5,    5,    0, 1};
    tbl[1]  = '{6,    7,    6,    3,    3,    3,    2, 3};
    tbl[2]  = '{6,    7,    7,    7,    7,    1,    8, 8};
    tbl[3]  = '{0,    1023, 1023, 1023, 1023, 0,    0, 1};
    tbl[4]  = '{1,    1023, 1023, 1023, 1023, 0,    0, 1};
    tbl[5]  = '{1023, 1022, 1022, 1022, 1022, 1022, 0, 1};
    tbl[6]  = '{1023, 1023, 1023, 5,    5,    5,    2, 3};
    tbl[7]  = '{5,    1023, 1023, 1023, 1023, 2,    8, 8};
    tbl[8]  = '{2,    1022, 1022, 1022, 1022, 0,    0, 1};
    tbl[9]  = '{512,  1023, 1023, 1023, 1023, 511,  0, 1};
    tbl[10] = '{513,  1023, 1023, 1023, 1023, 510,  8, 8};

    Reset = 1'b1; Req = 1'b0; Ack = 1'b0; Limit = '0; Rand = '0;
    #1;
    check("reset value",   Value,   0);
    check("reset valid",   Valid,   0);
    check("reset busy",    Busy,    0);
    check("reset rejects", Rejects, 0);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check("idle no req", Busy, 0);

    for (int t = 0; t < 11; t++) begin
      cur_r[0] = tbl[t].r0; cur_r[1] = tbl[t].r1; cur_r[2] = tbl[t].r2;
      for (int k = 3; k < MT; k++) cur_r[k] = tbl[t].rest;
      run_txn(tbl[t].limit, tbl[t].ev, tbl[t].er, tbl[t].elat, 1'b0,
              $sformatf("vec%0d", t));
    end

    // Req and Ack together in DONE: back to IDLE with no new request
    cur_r[0] = 3; for (int k = 1; k < MT; k++) cur_r[k] = 3;
    run_txn(6, 3, 0, 1, 1'b1, "req_ack_done");

    // Reset in the middle of sampling clears outputs without a clock edge
    @(negedge Clk);
    Req = 1'b1; Limit = 10'd6; Rand = 10'd7;
    @(negedge Clk);
    Req = 1'b0;
    repeat (3) @(negedge Clk);
    check("pre_reset rejects", Rejects, 3);
    check("pre_reset busy",    Busy,    1);
    #2 Reset = 1'b1;
    #1;
    check("async_reset value",   Value,   0);
    check("async_reset valid",   Valid,   0);
    check("async_reset busy",    Busy,    0);
    check("async_reset rejects", Rejects, 0);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check("post_reset idle", Busy, 0);
    cur_r[0] = 7; cur_r[1] = 4; for (int k = 2; k < MT; k++) cur_r[k] = 0;
    run_txn(6, 4, 1, 2, 1'b0, "post_reset");

    // Randomized transactions against the reference model
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) lim = $urandom_range(0, 8);
      else                           lim = $urandom_range(0, 1023);
      if ($urandom_range(0, 2) == 0)
        for (int k = 0; k < MT; k++) cur_r[k] = 1023;
      else
        for (int k = 0; k < MT; k++) cur_r[k] = $urandom_range(0, 1023);
      model(lim, ev, er, elat);
      run_txn(lim, ev, er, elat, 1'($urandom_range(0, 1)),
              $sformatf("rnd%0d L=%0d", t, lim));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
